prod_serializer: RTL and testbench
==================================

PROD_SERIALIZER -- requirements
Module: prod_serializer

Interface
REQ-001 SHALL have parameter PW, default 1142, meaning product width in bits (booth product width for 571x571).
REQ-002 SHALL have parameter WW, default 64, meaning output word width in bits.
REQ-003 SHALL derive NW = ceil(PW/WW), which is 18 at defaults, and IW = ceil(log2(NW)), which is 5 at defaults.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset: asserted when 0, released synchronously to clk.
REQ-006 in_valid  input  1  product present on in_data this cycle.
REQ-007 in_data  input  PW  signed two's-complement product.
REQ-008 in_ready  output  1  block can capture a product this cycle.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_ready  input  1  downstream accepts the word.
REQ-011 out_data  output  WW  current product word, least-significant word first.
REQ-012 out_idx  output  IW  index of the current word, 0..NW-1.
REQ-013 out_last  output  1  current word is word NW-1.
REQ-014 overflow  output  1  one-cycle pulse when a product is dropped.

Function
REQ-015 SHALL implement two states: IDLE and SEND.
REQ-016 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-017 When in_valid=1 and in_ready=1, the block SHALL capture in_data into an internal PW-bit hold register, set the word index to 0, and enter SEND on the next edge.
REQ-018 Latency SHALL be one cycle: a capture at edge N presents word 0 with out_valid=1 after edge N.
REQ-019 In SEND, out_valid SHALL be 1 and out_data SHALL equal hold[k*WW +: WW], where k = out_idx.
REQ-020 For the final word, bits above PW-1 SHALL be sign-extended from hold[PW-1]; at defaults this is 54 data bits plus 10 sign bits.
REQ-021 out_last SHALL be 1 exactly when out_idx = NW-1 and out_valid = 1.
REQ-022 On out_valid=1 and out_ready=1 with out_idx < NW-1, out_idx SHALL increment by 1.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-024 In SEND, in_ready SHALL be 1 only while the last word is being accepted (out_last=1 and out_ready=1); otherwise it SHALL be 0.
REQ-025 On last-word acceptance with in_valid=1, the block SHALL capture the new product, reset out_idx to 0 and stay in SEND, so no idle bubble occurs.
REQ-026 On last-word acceptance with in_valid=0, the block SHALL return to IDLE.
REQ-027 When in_valid=1 and in_ready=0, the product SHALL be discarded, overflow SHALL pulse high for that cycle, and the transfer in progress SHALL be unaffected.
REQ-028 The hold register SHALL change only on capture.
REQ-029 out_idx SHALL never exceed NW-1; there is no wrap other than the reset to 0 on capture.

Reset
REQ-030 Asserting rst (0) SHALL immediately force: state=IDLE, out_valid=0, out_idx=0, out_last=0, overflow=0, out_data=0, hold=0.
REQ-031 Reset asserted mid-transfer SHALL abandon that transfer; no further words of that product SHALL appear after release.
REQ-032 In the first cycle after release, in_ready SHALL be 1.

Verification
REQ-033 Capture in_data=1 with out_ready=1 held -> 18 consecutive words: word0=64'h1, words 1..17=0, out_last only on idx 17, in_ready=0 on idx 0..16.
REQ-034 Capture in_data=all ones (-1) -> all 18 words are 64'hFFFF_FFFF_FFFF_FFFF, including the 10 sign-extended bits of word 17.
REQ-035 Hold out_ready=0 for 5 cycles at idx 3, then release -> word 3 is held unchanged for 5 cycles, no word is skipped or duplicated, and word 17 follows 14 accepts later.
REQ-036 Assert in_valid with product B during the cycle word 17 of product A is accepted -> word 0 of B appears on the next cycle, out_valid never drops to 0, and overflow stays 0.
REQ-037 Assert in_valid at idx 5 -> overflow=1 for exactly 1 cycle, and product A's words 6..17 are unchanged.
REQ-038 Assert rst=0 asynchronously at idx 9 -> outputs clear immediately; after release in_ready=1, out_valid=0, and a new capture restarts at idx 0.

Source files
------------

// File: rtl/prod_serializer.sv
// Wide-product serializer: captures a signed PW-bit product and emits it as
// NW words of WW bits, least-significant first, with ready/valid on both sides.
module prod_serializer #(
  parameter int unsigned PW = 1142,
  parameter int unsigned WW = 64,
  localparam int unsigned NW = (PW + WW - 1) / WW,
  localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [PW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WW-1:0] out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          overflow
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  state_t           state_q, state_d;
  logic [PW-1:0]    hold_q;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NW*WW-1:0] hold_ext;
  logic [WW-1:0]    words [NW];
  logic             is_last, capture, accept;

  // Sign-fill the padding above PW-1 so the final word reads as a signed value.
  always_comb begin
    hold_ext           = {(NW*WW){hold_q[PW-1]}};
    hold_ext[PW-1:0]   = hold_q;
  end

  always_comb begin
    for (int unsigned k = 0; k < NW; k++) begin
      words[k] = hold_ext[k*WW +: WW];
    end
  end

  always_comb begin
    out_valid = (state_q == SEND);
    is_last   = out_valid && (idx_q == LAST_IDX);
    out_last  = is_last;
    in_ready  = !out_valid || (is_last && out_ready);
    capture   = in_valid && in_ready;
    overflow  = in_valid && !in_ready;
    accept    = out_valid && out_ready;
    out_idx   = idx_q;
    out_data  = out_valid ? words[idx_q] : '0;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (accept) begin
          if (is_last) begin
            // A capture on the last accept chains straight into the next product.
            idx_d = '0;
            if (!capture) state_d = IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) hold_q <= in_data;
    end
  end

endmodule

// File: tb/tb_prod_serializer.sv
// Scoreboard bench for prod_serializer: a predictor queues the expected words of
// each accepted product, a negedge monitor pops and compares them.
module tb_prod_serializer;

  localparam int unsigned PW = 1142;
  localparam int unsigned WW = 64;
  localparam int unsigned NW = (PW + WW - 1) / WW;
  localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [PW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WW-1:0] data;
    int unsigned   idx;
  } exp_t;

  exp_t exp_q[$];

  logic signed [NW*WW-1:0] ext, sh;
  logic model_rdy;

  prod_serializer #(.PW(PW), .WW(WW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Predictor: a product is taken whenever nothing remains to be sent at this edge.
  always @(posedge clk) begin
    if (rst && in_valid && exp_q.size() == 0) begin
      ext = $signed(in_data);
      for (int k = 0; k < int'(NW); k++) begin
        sh = ext >>> (k * WW);
        exp_q.push_back('{data: sh[WW-1:0], idx: k});
      end
    end
  end

  always @(negedge rst) exp_q.delete();

  always @(negedge clk) begin
    model_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
    chk("in_ready", WW'(in_ready), WW'(model_rdy));
    chk("overflow", WW'(overflow), WW'(in_valid && !model_rdy));
    chk("out_valid", WW'(out_valid), WW'(exp_q.size() != 0));
    if (exp_q.size() != 0 && out_valid) begin
      chk("out_data", out_data, exp_q[0].data);
      chk("out_idx", WW'(out_idx), WW'(exp_q[0].idx));
      chk("out_last", WW'(out_last), WW'(exp_q[0].idx == NW - 1));
    end
    if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] rand_prod();
    logic [PW-1:0] d = '0;
    for (int i = 0; i < int'(PW / 32) + 1; i++) d = (d << 32) | PW'($urandom());
    return d;
  endfunction

  task automatic send(input logic [PW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idx(input int unsigned target);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid && out_idx == IW'(target)) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("wait_idx_timeout", WW'(found), WW'(1));
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", WW'(out_valid), '0);
    chk("rst_out_idx", WW'(out_idx), '0);
    chk("rst_out_last", WW'(out_last), '0);
    chk("rst_overflow", WW'(overflow), '0);
    chk("rst_out_data", out_data, '0);
    step();
    step();
    rst = 1'b1;
    step();

    // Single-bit product, then all-ones product with sign-filled top word.
    send(PW'(1));
    repeat (NW + 2) step();
    send('1);
    repeat (NW + 2) step();

    // Backpressure at word 3 for five cycles.
    send(rand_prod());
    wait_idx(3);
    out_ready = 1'b0;
    repeat (5) step();
    out_ready = 1'b1;
    repeat (NW + 2) step();

    // Back-to-back product offered while the last word is accepted.
    send(rand_prod());
    wait_idx(NW - 1);
    in_valid = 1'b1;
    in_data  = rand_prod();
    step();
    in_valid = 1'b0;
    chk("chain_out_valid", WW'(out_valid), WW'(1));
    chk("chain_out_idx", WW'(out_idx), '0);
    repeat (NW + 2) step();

    // Product offered mid-transfer is dropped.
    send(rand_prod());
    wait_idx(5);
    in_valid = 1'b1;
    in_data  = rand_prod();
    step();
    in_valid = 1'b0;
    repeat (NW + 2) step();

    // Asynchronous reset mid-transfer.
    send(rand_prod());
    wait_idx(9);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", WW'(out_valid), '0);
    chk("arst_out_idx", WW'(out_idx), '0);
    chk("arst_out_last", WW'(out_last), '0);
    chk("arst_out_data", out_data, '0);
    chk("arst_in_ready", WW'(in_ready), WW'(1));
    step();
    rst = 1'b1;
    step();
    send(rand_prod());
    repeat (NW + 2) step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(7) == 0);
      in_data   = rand_prod();
      out_ready = ($urandom_range(3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (NW + 4) step();
    chk("drain_empty", WW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
